// File: rtl/moore_seq_det_if.sv
`default_nettype none
// ============================================================================
//  Module      : moore_seq_det_if
//  Description : Signal bundle for the Moore serial sequence detector.
//                Carries the serial bit stream, pattern load, overlap mode,
//                the detect flag and (optionally) the match counter.
//  Ports       : en, x, pat[N-1:0], pat_ld, ovl   (master -> slave)
//                z, match_cnt[CW-1:0]             (slave  -> master)
//  Config      : MOORE_SEQ_CNT_EN adds match_cnt to the bundle and modports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface moore_seq_det_if #(
    parameter int N  = 4,
    parameter int CW = 8
);
    logic         en;
    logic         x;
    logic [N-1:0] pat;
    logic         pat_ld;
    logic         ovl;
    logic         z;
`ifdef MOORE_SEQ_CNT_EN
    logic [CW-1:0] match_cnt;

    modport master (output en, x, pat, pat_ld, ovl, input z, match_cnt);
    modport slave  (input en, x, pat, pat_ld, ovl, output z, match_cnt);
`else
    modport master (output en, x, pat, pat_ld, ovl, input z);
    modport slave  (input en, x, pat, pat_ld, ovl, output z);
`endif
endinterface
`default_nettype wire

// File: rtl/moore_seq_det.sv
`default_nettype none
// ============================================================================
//  Module      : moore_seq_det
//  Description : Moore serial pattern detector with programmable N-bit
//                pattern and selectable overlapping / non-overlapping mode.
//                z is decoded purely from the registered state class.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous active-low reset
//                bus    - moore_seq_det_if.slave (en, x, pat, pat_ld, ovl,
//                         z, match_cnt)
//  Config      : MOORE_SEQ_CNT_EN - when defined, a saturating CW-bit count
//                of detections is kept and driven on bus.match_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module moore_seq_det #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    moore_seq_det_if.slave    bus
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);

    typedef enum logic [0:0] {
        S_SEARCH = 1'b0,
        S_MATCH  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pat_q,   pat_d;
    logic [N-1:0]   hist_q,  hist_d;
    logic [FW-1:0]  fill_q,  fill_d;
    logic           accept;

    // A bit is consumed only when no pattern load is happening on this edge.
    assign accept = bus.en && !bus.pat_ld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_SEARCH;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;

        if (bus.pat_ld) begin
            pat_d  = bus.pat;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d = {hist_q[N-2:0], bus.x};
            if (state_q == S_MATCH && !bus.ovl) begin
                // Non-overlap: the new bit starts a fresh window.
                fill_d = FW'(1);
            end else if (fill_q < FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        // State class follows from the next register contents, so z rises
        // on the edge that shifts in the final pattern bit.
        if (fill_d == FILL_FULL && hist_d == pat_d) begin
            state_d = S_MATCH;
        end else begin
            state_d = S_SEARCH;
        end
    end

    assign bus.z = (state_q == S_MATCH);

`ifdef MOORE_SEQ_CNT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.pat_ld) begin
            cnt_d = '0;
        end else if (accept && state_d == S_MATCH && cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    // accept only feeds the counter; keep it referenced in the lean build.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_det.sv
`default_nettype none
// ============================================================================
//  Module      : tb_moore_seq_det
//  Description : Self-checking bench for moore_seq_det. Directed vectors with
//                constant expectations plus randomized traffic compared with
//                a reference model built on a queue of accepted bits.
//  Config      : MOORE_SEQ_CNT_EN - enables match_cnt checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_seq_det;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    moore_seq_det_if #(.N(4), .CW(8)) if4 ();
    moore_seq_det_if #(.N(2), .CW(2)) if2 ();

    moore_seq_det #(.N(4), .CW(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    moore_seq_det #(.N(2), .CW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Reference model: every accepted bit since the last reset/load, plus the
    // index where the current usable window begins.
    bit        mq[$];
    int        mstart;
    bit        mz;
    int        mcnt;
    bit [3:0]  mpat;

    task automatic model_clear();
        mq.delete();
        mstart = 0;
        mz     = 1'b0;
        mcnt   = 0;
    endtask

    task automatic model_edge(input bit r, input bit en, input bit x,
                              input bit ld, input bit ovl, input bit [3:0] p);
        if (!r) begin
            model_clear();
            mpat = 4'b0000;
        end else if (ld) begin
            model_clear();
            mpat = p;
        end else if (en) begin
            if (mz && !ovl) mstart = mq.size();
            mq.push_back(x);
            mz = 1'b0;
            if (mq.size() - mstart >= 4) begin
                mz = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (mq[mq.size() - 1 - i] != mpat[i]) mz = 1'b0;
            end
            if (mz && mcnt < 255) mcnt++;
        end
    endtask

    // One clock: drive dut4 (dut2 inputs are set separately), advance the
    // model, then check dut4 just after the edge.
    task automatic step(input bit r, input bit en, input bit x,
                        input bit ld, input bit ovl, input bit [3:0] p);
        rst_n      = r;
        if4.en     = en;
        if4.x      = x;
        if4.pat_ld = ld;
        if4.ovl    = ovl;
        if4.pat    = p;
        @(posedge clk);
        model_edge(r, en, x, ld, ovl, p);
        #1;
        chk("z_model", {31'd0, if4.z}, {31'd0, mz});
`ifdef MOORE_SEQ_CNT_EN
        chk("cnt_model", {24'd0, if4.match_cnt}, mcnt);
`endif
    endtask

    bit [7:0] zexp;
    bit [3:0] seq;
    bit       r_ovl;

    initial begin
        if2.en = 1'b0; if2.x = 1'b0; if2.pat_ld = 1'b0; if2.ovl = 1'b1; if2.pat = 2'b00;
        mpat = 4'b0000;
        model_clear();

        // Reset state
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        chk("reset_z", {31'd0, if4.z}, 32'd0);

        // Overlapping 1010 over 10101010: hits after bits 4, 6, 8
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
        zexp = 8'b1010_1000;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, (i % 2 == 0), 1'b0, 1'b1, 4'b1010);
            chk("ovl_z", {31'd0, if4.z}, {31'd0, zexp[i]});
        end
`ifdef MOORE_SEQ_CNT_EN
        chk("ovl_cnt", {24'd0, if4.match_cnt}, 32'd3);
`endif

        // Same stream, non-overlapping: hits after bits 4 and 8 only
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010);
        zexp = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, (i % 2 == 0), 1'b0, 1'b0, 4'b1010);
            chk("novl_z", {31'd0, if4.z}, {31'd0, zexp[i]});
        end
`ifdef MOORE_SEQ_CNT_EN
        chk("novl_cnt", {24'd0, if4.match_cnt}, 32'd2);
`endif

        // en toggling: z rises on 4th accepted bit and holds across en=0
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
        zexp = 8'b1100_0000;
        seq  = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 2 == 0), seq[3 - i / 2], 1'b0, 1'b1, 4'b1010);
            chk("entog_z", {31'd0, if4.z}, {31'd0, zexp[i]});
        end
`ifdef MOORE_SEQ_CNT_EN
        chk("entog_cnt", {24'd0, if4.match_cnt}, 32'd1);
`endif

        // Reload mid-sequence: accompanying bit dropped, history restarts
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1010);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1010);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        chk("reload_z", {31'd0, if4.z}, 32'd0);
        zexp = 8'b0000_1000;
        seq  = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, seq[3 - i], 1'b0, 1'b1, 4'b0110);
            chk("reload_seq_z", {31'd0, if4.z}, {31'd0, zexp[i]});
        end
`ifdef MOORE_SEQ_CNT_EN
        chk("reload_cnt", {24'd0, if4.match_cnt}, 32'd1);
`endif

        // Reset while matched aborts immediately; 3 bits cannot match
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
        chk("rst_abort_z", {31'd0, if4.z}, 32'd0);
`ifdef MOORE_SEQ_CNT_EN
        chk("rst_abort_cnt", {24'd0, if4.match_cnt}, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
            chk("post_rst_z", {31'd0, if4.z}, 32'd0);
        end

        // N=2, CW=2, pattern 11, ten ones: z from bit 2, count saturates at 3
        if2.pat = 2'b11; if2.pat_ld = 1'b1; if2.en = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        if2.pat_ld = 1'b0; if2.en = 1'b1; if2.x = 1'b1; if2.ovl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
            chk("sat_z", {31'd0, if2.z}, (i >= 1) ? 32'd1 : 32'd0);
`ifdef MOORE_SEQ_CNT_EN
            chk("sat_cnt", {30'd0, if2.match_cnt}, (i >= 3) ? 32'd3 : i);
`endif
        end
        if2.en = 1'b0;

        // Randomized traffic against the model
        r_ovl = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) r_ovl = ~r_ovl;
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 39) == 0),
                 r_ovl,
                 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
